// File: rtl/camfilt_pkg.sv
// Shared constants and helpers for the camera-filter colour path.
// Used by both the Y'UV->RGB decoder and its RGB->Y'UV counterpart.
//   PIX_W      packed pixel width (3 x 8-bit channels)
//   CH_W       channel width
//   CALC_W     signed width of every intermediate in the colour math
//   COEF_SHIFT fixed-point scale of the coefficients (/32)
//   C_*        coefficient constants (x/32): R<-V, G<-U, G<-V, B<-U
//   clamp8()   signed CALC_W-bit value -> 0..255
package camfilt_pkg;

  localparam int PIX_W      = 24;
  localparam int CH_W       = 8;
  localparam int CALC_W     = 18;
  localparam int COEF_SHIFT = 5;

  localparam int C_RV = 36;
  localparam int C_GU = 13;
  localparam int C_GV = 19;
  localparam int C_BU = 65;

  localparam logic signed [CALC_W-1:0] CH_MAX = CALC_W'(255);

  function automatic logic [CH_W-1:0] clamp8(input logic signed [CALC_W-1:0] x);
    if (x[CALC_W-1])
      return '0;
    else if (x > CH_MAX)
      return '1;
    else
      return x[CH_W-1:0];
  endfunction

endpackage

// File: rtl/yuv2rgb_pipe_if.sv
// Streaming bus of the Y'UV->RGB converter: Y'UV pixel in, RGB pixel out,
// each with valid/ready handshake and sof/eol sideband.
//   in_valid/in_ready/in_yuv/in_sof/in_eol       upstream side, in_yuv = {Y,U,V}
//   out_valid/out_ready/out_rgb/out_sof/out_eol  downstream side, out_rgb = {R,G,B}
//   modport slave  : converter view
//   modport master : source/sink view (upstream producer + downstream consumer)
interface yuv2rgb_pipe_if;
  import camfilt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_yuv;
  logic             in_sof;
  logic             in_eol;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_rgb;
  logic             out_sof;
  logic             out_eol;

  modport slave (
    input  in_valid, in_yuv, in_sof, in_eol, out_ready,
    output in_ready, out_valid, out_rgb, out_sof, out_eol
  );

  modport master (
    output in_valid, in_yuv, in_sof, in_eol, out_ready,
    input  in_ready, out_valid, out_rgb, out_sof, out_eol
  );

endinterface

// File: rtl/yuv2rgb_clamp.sv
// Saturates one signed CALC_W-bit colour channel to 8 bits.
//   din   signed intermediate channel value
//   dout  value clamped to 0..255
//   sat   1 when din was outside 0..255 (clamped low or high)
module yuv2rgb_clamp
  import camfilt_pkg::*;
(
  input  logic signed [CALC_W-1:0] din,
  output logic        [CH_W-1:0]   dout,
  output logic                     sat
);

  assign dout = clamp8(din);
  assign sat  = din[CALC_W-1] || (din > CH_MAX);

endmodule

// File: rtl/yuv2rgb_pipe.sv
// Pipelined Y'UV->RGB888 converter with /32 shift-add coefficients.
//   R = Y + (36v >>> 5)
//   G = Y - ((13u + 19v) >>> 5)
//   B = Y + (65u >>> 5)
// with u = U - UV_OFFSET, v = V - UV_OFFSET, each channel clamped to 0..255.
// Three stages share one advance enable, so a stalled output freezes the
// whole pipe and deasserts in_ready in the same cycle.
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   bus        yuv2rgb_pipe_if.slave streaming bus (see interface file)
//   sat_count  16-bit saturating count of output pixels with any clamped
//              channel; present only when YUV2RGB_SATCNT_EN is defined
// Parameter:
//   UV_OFFSET  subtracted from U and V (0 = unsigned, 128 = offset-binary)
// Build option: YUV2RGB_SATCNT_EN adds the sat_count port and counter.
module yuv2rgb_pipe
  import camfilt_pkg::*;
#(
  parameter int UV_OFFSET = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  yuv2rgb_pipe_if.slave        bus
`ifdef YUV2RGB_SATCNT_EN
  ,
  output logic [15:0]          sat_count
`endif
);

  localparam logic signed [CALC_W-1:0] UV_OFF = CALC_W'(UV_OFFSET);

  logic adv;

  // Stage 0 (combinational): offset removal and coefficient products
  logic signed [CALC_W-1:0] u_p0, v_p0;
  logic signed [CALC_W-1:0] m36v_p0, m13u_p0, m19v_p0, m65u_p0;

  // Stage 1 registers
  logic                     vld_p1, sof_p1, eol_p1;
  logic        [CH_W-1:0]   y_p1;
  logic signed [CALC_W-1:0] m36v_p1, m13u_p1, m19v_p1, m65u_p1;
  logic signed [CALC_W-1:0] y_ext_p1, r_sum_p1, g_sum_p1, b_sum_p1;

  // Stage 2 registers
  logic                     vld_p2, sof_p2, eol_p2;
  logic signed [CALC_W-1:0] r_p2, g_p2, b_p2;
  logic        [CH_W-1:0]   r8_p2, g8_p2, b8_p2;
  logic                     r_sat_p2, g_sat_p2, b_sat_p2;

  // Stage 3 registers (output)
  logic                     vld_p3, sof_p3, eol_p3;
  logic        [PIX_W-1:0]  rgb_p3;
  logic                     sat_p3;

  assign adv          = ~vld_p3 | bus.out_ready;
  assign bus.in_ready = adv;

  // ---- stage 0 -> 1 ----
  assign u_p0 = $signed({10'd0, bus.in_yuv[15:8]}) - UV_OFF;
  assign v_p0 = $signed({10'd0, bus.in_yuv[7:0]})  - UV_OFF;

  assign m36v_p0 = (v_p0 <<< 5) + (v_p0 <<< 2);
  assign m13u_p0 = (u_p0 <<< 3) + (u_p0 <<< 2) + u_p0;
  assign m19v_p0 = (v_p0 <<< 4) + (v_p0 <<< 1) + v_p0;
  assign m65u_p0 = (u_p0 <<< 6) + u_p0;

  // ---- stage 1 -> 2 ----
  assign y_ext_p1 = $signed({10'd0, y_p1});
  assign r_sum_p1 = y_ext_p1 + (m36v_p1 >>> COEF_SHIFT);
  assign g_sum_p1 = y_ext_p1 - ((m13u_p1 + m19v_p1) >>> COEF_SHIFT);
  assign b_sum_p1 = y_ext_p1 + (m65u_p1 >>> COEF_SHIFT);

  // ---- stage 2 -> 3 ----
  yuv2rgb_clamp u_clamp_r (.din(r_p2), .dout(r8_p2), .sat(r_sat_p2));
  yuv2rgb_clamp u_clamp_g (.din(g_p2), .dout(g8_p2), .sat(g_sat_p2));
  yuv2rgb_clamp u_clamp_b (.din(b_p2), .dout(b8_p2), .sat(b_sat_p2));

  // Control: stage valids and the visible output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      rgb_p3 <= '0;
      sof_p3 <= 1'b0;
      eol_p3 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      rgb_p3 <= {r8_p2, g8_p2, b8_p2};
      sof_p3 <= sof_p2;
      eol_p3 <= eol_p2;
    end
  end

  // Datapath: no reset; contents only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      y_p1    <= bus.in_yuv[23:16];
      sof_p1  <= bus.in_sof;
      eol_p1  <= bus.in_eol;
      m36v_p1 <= m36v_p0;
      m13u_p1 <= m13u_p0;
      m19v_p1 <= m19v_p0;
      m65u_p1 <= m65u_p0;

      r_p2    <= r_sum_p1;
      g_p2    <= g_sum_p1;
      b_p2    <= b_sum_p1;
      sof_p2  <= sof_p1;
      eol_p2  <= eol_p1;

      sat_p3  <= r_sat_p2 | g_sat_p2 | b_sat_p2;
    end
  end

  assign bus.out_valid = vld_p3;
  assign bus.out_rgb   = rgb_p3;
  assign bus.out_sof   = sof_p3;
  assign bus.out_eol   = eol_p3;

`ifdef YUV2RGB_SATCNT_EN
  logic [15:0] sat_cnt;

  // Counts only on the handshake, so a stalled pixel is counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_cnt <= '0;
    else if (vld_p3 && bus.out_ready && sat_p3 && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end

  assign sat_count = sat_cnt;
`else
  logic unused_sat;
  assign unused_sat = sat_p3;
`endif

endmodule

// File: tb/tb_yuv2rgb_pipe.sv
module tb_yuv2rgb_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  yuv2rgb_pipe_if bus0 ();
  yuv2rgb_pipe_if bus1 ();

`ifdef YUV2RGB_SATCNT_EN
  logic [15:0] sat0, sat1;
`endif

  yuv2rgb_pipe #(.UV_OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef YUV2RGB_SATCNT_EN
    , .sat_count(sat0)
`endif
  );

  yuv2rgb_pipe #(.UV_OFFSET(128)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef YUV2RGB_SATCNT_EN
    , .sat_count(sat1)
`endif
  );

  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic vld, input logic [23:0] yuv,
                       input logic sof, input logic eol);
    if (s == 0) begin
      bus0.in_valid = vld; bus0.in_yuv = yuv; bus0.in_sof = sof; bus0.in_eol = eol;
    end else begin
      bus1.in_valid = vld; bus1.in_yuv = yuv; bus1.in_sof = sof; bus1.in_eol = eol;
    end
  endtask

  function automatic logic ov(input int s);
    return (s == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction

  function automatic logic [23:0] orgb(input int s);
    return (s == 0) ? bus0.out_rgb : bus1.out_rgb;
  endfunction

  // Single pixel into an empty pipe with out_ready=1: invisible for two
  // edges after acceptance, valid after the third, gone after the fourth.
  task automatic send_check(input int s, input logic [23:0] yuv,
                            input logic [23:0] exp, input string tag);
    drive(s, 1'b1, yuv, 1'b0, 1'b0);
    step();
    drive(s, 1'b0, 24'h0, 1'b0, 1'b0);
    chk({tag, "_lat1"}, ov(s), 1'b0);
    step();
    chk({tag, "_lat2"}, ov(s), 1'b0);
    step();
    chk({tag, "_vld"}, ov(s), 1'b1);
    chk({tag, "_rgb"}, orgb(s), exp);
    step();
    chk({tag, "_once"}, ov(s), 1'b0);
  endtask

  function automatic logic [23:0] pix(input int i);
    logic [7:0] y, u, v;
    y = 8'(i * 16 + 3);
    u = 8'(i * 13);
    v = 8'(255 - i * 11);
    return {y, u, v};
  endfunction

  function automatic logic [7:0] sat8(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  // Reference for UV_OFFSET=0: floor division by 32 of the scaled terms.
  function automatic logic [23:0] ref_rgb(input logic [23:0] yuv);
    int y, u, v, r, g, b;
    y = int'(yuv[23:16]);
    u = int'(yuv[15:8]);
    v = int'(yuv[7:0]);
    r = y + ((36 * v) >>> 5);
    g = y - ((13 * u + 19 * v) >>> 5);
    b = y + ((65 * u) >>> 5);
    return {sat8(r), sat8(g), sat8(b)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [23:0] hold_rgb;
  logic        hold_sof, hold_eol, stalled;
  int          sent, rcv, cyc;

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 24'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 24'h0, 1'b0, 1'b0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    step();

    // Reset state
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_out_rgb",   bus0.out_rgb, 24'h0);
    chk("rst_out_sof",   bus0.out_sof, 1'b0);
    chk("rst_out_eol",   bus0.out_eol, 1'b0);
    chk("rst_in_ready",  bus0.in_ready, 1'b1);
`ifdef YUV2RGB_SATCNT_EN
    chk("rst_sat_count", sat0, 16'd0);
`endif
    rst = 1'b0;
    step();

    // T1..T3, unsigned U/V
    send_check(0, 24'h640000, 24'h646464, "t1");
`ifdef YUV2RGB_SATCNT_EN
    chk("t1_sat_count", sat0, 16'd0);
`endif
    send_check(0, 24'hC80064, 24'hFF8DC8, "t2");
`ifdef YUV2RGB_SATCNT_EN
    chk("t2_sat_count", sat0, 16'd1);
`endif
    send_check(0, 24'h32C800, 24'h3200FF, "t3");
`ifdef YUV2RGB_SATCNT_EN
    chk("t3_sat_count", sat0, 16'd2);
`endif

    // T4, offset-binary U/V
    send_check(1, 24'h808080, 24'h808080, "t4_mid");
    send_check(1, 24'h0A0000, 24'h008A00, "t4_low");
`ifdef YUV2RGB_SATCNT_EN
    chk("t4_sat_count", sat1, 16'd1);
`endif

    // T5: 16-pixel line pair under random backpressure
    sent = 0; rcv = 0; cyc = 0; stalled = 1'b0;
    hold_rgb = 24'h0; hold_sof = 1'b0; hold_eol = 1'b0;
    while (rcv < 16 && cyc < 400) begin
      if (stalled) begin
        chk("t5_hold_vld", bus0.out_valid, 1'b1);
        chk("t5_hold_rgb", bus0.out_rgb, hold_rgb);
        chk("t5_hold_sof", bus0.out_sof, hold_sof);
        chk("t5_hold_eol", bus0.out_eol, hold_eol);
      end
      bus0.out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 16)
        drive(0, 1'b1, pix(sent), sent == 0, (sent == 7) || (sent == 15));
      else
        drive(0, 1'b0, 24'h0, 1'b0, 1'b0);
      #1;
      stalled = bus0.out_valid && !bus0.out_ready;
      if (stalled)
        chk("t5_in_ready_low", bus0.in_ready, 1'b0);
      if (bus0.out_valid && bus0.out_ready) begin
        chk("t5_rgb", bus0.out_rgb, ref_rgb(pix(rcv)));
        chk("t5_sof", bus0.out_sof, rcv == 0);
        chk("t5_eol", bus0.out_eol, (rcv == 7) || (rcv == 15));
        rcv++;
      end
      if (bus0.in_valid && bus0.in_ready)
        sent++;
      hold_rgb = bus0.out_rgb;
      hold_sof = bus0.out_sof;
      hold_eol = bus0.out_eol;
      step();
      cyc++;
    end
    chk("t5_received", rcv, 16);
    drive(0, 1'b0, 24'h0, 1'b0, 1'b0);
    bus0.out_ready = 1'b1;
    step();
    chk("t5_drained", bus0.out_valid, 1'b0);

    // T6: async reset with three pixels in flight
    drive(0, 1'b1, 24'hC80064, 1'b1, 1'b0);
    step();
    drive(0, 1'b1, 24'h32C800, 1'b0, 1'b0);
    step();
    drive(0, 1'b1, 24'h640000, 1'b0, 1'b1);
    step();
    drive(0, 1'b0, 24'h0, 1'b0, 1'b0);
    chk("t6_pre_vld", bus0.out_valid, 1'b1);
`ifdef YUV2RGB_SATCNT_EN
    chk("t6_pre_sat_nonzero", sat0 != 16'd0, 1'b1);
`endif
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", bus0.out_valid, 1'b0);
    chk("t6_rst_rgb", bus0.out_rgb, 24'h0);
`ifdef YUV2RGB_SATCNT_EN
    chk("t6_rst_sat", sat0, 16'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_post_vld0", bus0.out_valid, 1'b0);
    step();
    chk("t6_post_vld1", bus0.out_valid, 1'b0);
    step();
    chk("t6_post_vld2", bus0.out_valid, 1'b0);
    send_check(0, 24'h4D0000, 24'h4D4D4D, "t6_new");

    $display("%0d/%0d checks passed", total - failed, total);
    $finish;
  end

endmodule
